// File: rtl/rc4_xor_stream_if.sv
// rc4_xor_stream_if
//   Handshake bundle for the RC4 keystream XOR stage.
//   Contains the control (start/msg_len/busy/done), the keystream input
//   (ks_*), the message input (din_*) and the result output (dout_*).
//   master: the side that drives start, keystream, message and dout_ready.
//   slave : the XOR stage itself.
interface rc4_xor_stream_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             ks_valid;
  logic [7:0]       ks_data;
  logic             ks_ready;
  logic             din_valid;
  logic [7:0]       din_data;
  logic             din_ready;
  logic             dout_valid;
  logic [7:0]       dout_data;
  logic             dout_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, msg_len, ks_valid, ks_data, din_valid, din_data, dout_ready,
    input  ks_ready, din_ready, dout_valid, dout_data, busy, done
  );

  modport slave (
    input  start, msg_len, ks_valid, ks_data, din_valid, din_data, dout_ready,
    output ks_ready, din_ready, dout_valid, dout_data, busy, done
  );
endinterface

// File: rtl/rc4_xor_stream.sv
// rc4_xor_stream
//   Consumer end of the RC4 keystream: buffers keystream bytes in a small
//   FIFO and XORs each with one message byte (encrypt == decrypt).
//   Valid/ready backpressure on keystream, message and result sides.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low (aborts a message, no done)
//   bus    : rc4_xor_stream_if.slave
//            start/msg_len in, busy/done out
//            ks_valid/ks_data in, ks_ready out
//            din_valid/din_data in, din_ready out
//            dout_valid/dout_data out (registered), dout_ready in
// Configuration
//   RC4_DROP_EN : when defined, the first DROP_BYTES keystream bytes of
//                 every message are accepted and discarded (RC4-drop[n]).
module rc4_xor_stream #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16,
  parameter int DROP_BYTES = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  rc4_xor_stream_if.slave  bus
);
  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DROP, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;
  logic [LEN_W-1:0] r_rem;
  logic             r_dvld;
  logic [7:0]       r_ddata;
  logic             r_busy, r_done;

  logic w_ks_ready, w_din_ready, w_push, w_pop, w_out_hs, w_start;

`ifdef RC4_DROP_EN
  localparam int DW = (DROP_BYTES > 1) ? $clog2(DROP_BYTES) : 1;
  logic [DW-1:0] r_drop;
  logic          w_ks_hs;
  assign w_ks_hs = bus.ks_valid & w_ks_ready;
`endif

  // Full test uses the registered count only, so a same-cycle pop never
  // lets a push into a full FIFO.
`ifdef RC4_DROP_EN
  assign w_ks_ready = (r_state == S_DROP) | ((r_state == S_RUN) & (r_cnt < FULL));
`else
  assign w_ks_ready = (r_state == S_RUN) & (r_cnt < FULL);
`endif

  assign w_din_ready = (r_state == S_RUN) & (r_rem != '0) & (r_cnt != '0) &
                       (~r_dvld | bus.dout_ready);
  assign w_push   = bus.ks_valid & w_ks_ready & (r_state == S_RUN);
  assign w_pop    = bus.din_valid & w_din_ready;
  assign w_out_hs = r_dvld & bus.dout_ready;
  assign w_start  = bus.start & (r_state == S_IDLE);

  assign bus.ks_ready   = w_ks_ready;
  assign bus.din_ready  = w_din_ready;
  assign bus.dout_valid = r_dvld;
  assign bus.dout_data  = r_ddata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

  // Storage needs no reset: it is only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.ks_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvld  <= 1'b0;
      r_ddata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef RC4_DROP_EN
      r_drop  <= '0;
`endif
    end else begin
      // FIFO pointers/count; an accepted start flushes leftover keystream.
      if (w_start) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
          2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
          default: ;
        endcase
      end

      // Result register: din_ready already guarantees the slot is free.
      if (w_pop) begin
        r_dvld  <= 1'b1;
        r_ddata <= bus.din_data ^ r_mem[r_rptr];
        r_rem   <= r_rem - LEN_W'(1);
      end else if (w_out_hs) begin
        r_dvld  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rem  <= bus.msg_len;
            r_busy <= 1'b1;
`ifdef RC4_DROP_EN
            r_drop <= '0;
`endif
            if (bus.msg_len == '0) r_state <= S_DONE;
`ifdef RC4_DROP_EN
            else                   r_state <= S_DROP;
`else
            else                   r_state <= S_RUN;
`endif
          end
        end
        S_DROP: begin
`ifdef RC4_DROP_EN
          if (w_ks_hs) begin
            r_drop <= r_drop + DW'(1);
            if (r_drop == DW'(DROP_BYTES - 1)) r_state <= S_RUN;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_RUN: begin
          // Last result leaves when nothing is left to accept.
          if ((r_rem == '0) && w_out_hs) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          // Entry from RUN already raised done; the zero-length entry
          // raises it here so done is still a single pulse.
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
